interrupt_controller: RTL and testbench

//  Parametrised trap/interrupt controller. It synchronises NUM_IRQ asynchronous interrupt lines and latches them as

---
 rtl/interrupt_controller.sv | 104 ++++++++++
 tb/tb_interrupt_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises and latches interrupt lines, arbitrates them against
// illegal-instruction exceptions, and presents one held trap request with handler tracking.
// Ports:
//   clk, nrst (async active-low)
//   irq_in, irq_en, irq_mask          : interrupt lines and enables
//   illegal_inst, epc_in              : memory-stage exception and its PC
//   mtvec_base, mtvec_mode            : trap vector configuration
//   trap_ack, mret                    : pipeline accept / handler return
//   trap_req, trap_is_irq, trap_cause : held trap request and its cause
//   trap_pc, trap_target, flush       : captured PC, redirect PC, pipeline flush
//   irq_pending, in_handler           : mip view and handler status
module interrupt_controller #(
  parameter int                 NUM_IRQ     = 16,
  parameter int                 CAUSE_BASE  = 16,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               irq_en,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               illegal_inst,
  input  logic [31:0]        epc_in,
  input  logic [31:0]        mtvec_base,
  input  logic [1:0]         mtvec_mode,
  input  logic               trap_ack,
  input  logic               mret,
  output logic               trap_req,
  output logic               trap_is_irq,
  output logic [31:0]        trap_cause,
  output logic [31:0]        trap_pc,
  output logic [31:0]        trap_target,
  output logic [3:0]         flush,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               in_handler
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;
  state_t state, state_nx;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s, s_prev, qual, clr;
  logic [IW-1:0] sel, cap_idx;
  logic take, ack, cap_irq;
  logic [30:0] code_nx, cap_code;
  logic [31:0] target_nx;
  assign s = sync_q[SYNC_STAGES-1];
  assign qual = irq_pending & irq_mask & {NUM_IRQ{irq_en}};
  assign ack = state == REQ && trap_ack;
  // only edge sources latch; the acked source is cleared unless a new edge arrives the same cycle
  assign clr = (ack && cap_irq) ? NUM_IRQ'(1) << cap_idx : '0;
  assign take = (state == IDLE && (illegal_inst || |qual)) || (state == HANDLER && illegal_inst);
  assign code_nx = illegal_inst ? 31'd2 : 31'(CAUSE_BASE) + 31'(sel);
  assign target_nx = (!illegal_inst && mtvec_mode == 2'd1) ? mtvec_base + (32'(code_nx) << 2) : mtvec_base;
  assign trap_req = state == REQ;
  assign in_handler = state == HANDLER;
  assign trap_is_irq = cap_irq;
  assign trap_cause = {cap_irq, cap_code};
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev <= '0;
      irq_pending <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_prev <= s;
      irq_pending <= (EDGE_MASK & ((irq_pending & ~clr) | (s & ~s_prev))) | (~EDGE_MASK & s);
    end
  end
  // lowest index wins: scan downward so the last hit is the smallest
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (qual[i]) sel = IW'(i);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    flush = '0;
    if (take) state_nx = REQ;
    else if (ack) begin
      state_nx = HANDLER;
      flush = 4'hf;
    end else if (state == HANDLER && mret) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cap_irq <= 1'b0;
      cap_code <= '0;
      cap_idx <= '0;
      trap_pc <= '0;
      trap_target <= '0;
    end else if (take) begin
      cap_irq <= !illegal_inst;
      cap_code <= code_nx;
      cap_idx <= sel;
      trap_pc <= epc_in;
      trap_target <= target_nx;
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vectors plus hand sequences for the interrupt controller
module tb_interrupt_controller;
  logic clk = 0, nrst = 0;
  logic [15:0] irq_in, irq_mask, irq_pending;
  logic irq_en, illegal_inst, trap_ack, mret;
  logic [31:0] epc_in, mtvec_base, trap_cause, trap_pc, trap_target;
  logic [1:0] mtvec_mode;
  logic trap_req, trap_is_irq, in_handler;
  logic [3:0] flush;
  int total = 0, bad = 0;

  interrupt_controller #(.NUM_IRQ(16), .CAUSE_BASE(16), .EDGE_MASK(16'h0028), .SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .irq_in(irq_in), .irq_en(irq_en), .irq_mask(irq_mask),
    .illegal_inst(illegal_inst), .epc_in(epc_in), .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode),
    .trap_ack(trap_ack), .mret(mret), .trap_req(trap_req), .trap_is_irq(trap_is_irq),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_target(trap_target), .flush(flush),
    .irq_pending(irq_pending), .in_handler(in_handler));

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [1:0]  mode;
    logic [31:0] base;
    logic [31:0] cause;
    logic [31:0] target;
    logic        edge_src;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic do_reset;
    nrst = 0;
    irq_in = '0; irq_mask = '0; irq_en = 0; illegal_inst = 0; trap_ack = 0; mret = 0;
    epc_in = '0; mtvec_base = '0; mtvec_mode = '0;
    repeat (2) tick;
    nrst = 1;
    tick;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3,  2'd0, 32'h100,      32'h80000013, 32'h100, 1'b1};
    vecs[1] = '{3,  2'd1, 32'h100,      32'h80000013, 32'h14C, 1'b1};
    vecs[2] = '{0,  2'd1, 32'h200,      32'h80000010, 32'h240, 1'b0};
    vecs[3] = '{5,  2'd2, 32'h300,      32'h80000015, 32'h300, 1'b1};
    vecs[4] = '{15, 2'd1, 32'hFFFFFFF0, 32'h8000001F, 32'h6C,  1'b0};

    do_reset;
    chk("rst_trap_req", 32'(trap_req), 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_pending", 32'(irq_pending), 0);
    chk("rst_in_handler", 32'(in_handler), 0);
    chk("rst_flush", 32'(flush), 0);

    foreach (vecs[v]) begin
      do_reset;
      irq_en = 1; irq_mask = '1;
      mtvec_base = vecs[v].base; mtvec_mode = vecs[v].mode;
      epc_in = 32'h1000 + 32'(v) * 4;
      irq_in[vecs[v].src] = 1;
      repeat (3) tick;
      chk($sformatf("v%0d_pending", v), 32'(irq_pending[vecs[v].src]), 1);
      chk($sformatf("v%0d_req_early", v), 32'(trap_req), 0);
      tick;
      chk($sformatf("v%0d_req", v), 32'(trap_req), 1);
      chk($sformatf("v%0d_cause", v), trap_cause, vecs[v].cause);
      chk($sformatf("v%0d_target", v), trap_target, vecs[v].target);
      chk($sformatf("v%0d_pc", v), trap_pc, 32'h1000 + 32'(v) * 4);
      chk($sformatf("v%0d_is_irq", v), 32'(trap_is_irq), 1);
      irq_in = '0;
      trap_ack = 1;
      #1;
      chk($sformatf("v%0d_flush", v), 32'(flush), 32'hf);
      tick;
      trap_ack = 0;
      #1;
      chk($sformatf("v%0d_flush_off", v), 32'(flush), 0);
      chk($sformatf("v%0d_req_off", v), 32'(trap_req), 0);
      chk($sformatf("v%0d_in_handler", v), 32'(in_handler), 1);
      chk($sformatf("v%0d_pend_ack", v), 32'(irq_pending[vecs[v].src]), vecs[v].edge_src ? 0 : 1);
      mret = 1;
      tick;
      mret = 0;
      chk($sformatf("v%0d_mret", v), 32'(in_handler), 0);
    end

    // exception beats interrupt in the same cycle
    do_reset;
    irq_mask = '1; irq_in[0] = 1; mtvec_base = 32'h100; mtvec_mode = 2'd1;
    repeat (3) tick;
    chk("exc_pend0", 32'(irq_pending[0]), 1);
    chk("exc_no_req", 32'(trap_req), 0);
    irq_en = 1; illegal_inst = 1; epc_in = 32'h40;
    tick;
    illegal_inst = 0;
    chk("exc_req", 32'(trap_req), 1);
    chk("exc_cause", trap_cause, 32'h2);
    chk("exc_pc", trap_pc, 32'h40);
    chk("exc_is_irq", 32'(trap_is_irq), 0);
    chk("exc_target", trap_target, 32'h100);

    // interrupt arriving during handler is held until mret
    do_reset;
    irq_en = 1; irq_mask = '1; illegal_inst = 1; epc_in = 32'h80;
    tick;
    illegal_inst = 0; trap_ack = 1;
    tick;
    trap_ack = 0;
    chk("hnd_in", 32'(in_handler), 1);
    irq_in[5] = 1;
    tick;
    irq_in[5] = 0;
    repeat (4) tick;
    chk("hnd_pend5", 32'(irq_pending[5]), 1);
    chk("hnd_no_req", 32'(trap_req), 0);
    epc_in = 32'h500; mtvec_base = 32'h800; mtvec_mode = 2'd0;
    mret = 1;
    tick;
    mret = 0;
    chk("hnd_idle", 32'(in_handler), 0);
    chk("hnd_idle_req", 32'(trap_req), 0);
    tick;
    chk("hnd_req5", 32'(trap_req), 1);
    chk("hnd_cause5", trap_cause, 32'h80000015);

    // outputs frozen while waiting for ack
    for (int c = 0; c < 10; c++) begin
      irq_in = 16'($urandom); illegal_inst = 1'($urandom); mret = 1'($urandom);
      epc_in = $urandom; mtvec_base = $urandom; mtvec_mode = 2'($urandom); irq_mask = 16'($urandom);
      tick;
      chk("frz_req", 32'(trap_req), 1);
      chk("frz_cause", trap_cause, 32'h80000015);
      chk("frz_pc", trap_pc, 32'h500);
      chk("frz_target", trap_target, 32'h800);
    end

    // asynchronous reset while requesting
    irq_in = '1; trap_ack = 1;
    #2 nrst = 0;
    #1;
    chk("arst_req", 32'(trap_req), 0);
    chk("arst_flush", 32'(flush), 0);
    chk("arst_pending", 32'(irq_pending), 0);
    chk("arst_in_handler", 32'(in_handler), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
